hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 169 ++++++++++++++++
 tb/tb_hazard_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// ID-stage decode and hazard FSM: 1-cycle registered ID/EX control word; stall_o holds PC/IF-ID on load-use or multiply wait.
// flush_o squashes IF/ID on taken beq; define HAZARD_CONTROL_MULDIV_EN to enable multi-cycle multiply-class R ops.
module hazard_control #(
   parameter int MUL_LAT   = 3,
   parameter int FLUSH_CYC = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   input  logic [6:0] Op_i,
   input  logic [6:0] funct7_i,
   input  logic       is_equal_i,
   input  logic       load_use_i,
   output logic [7:0] Control_o,
   output logic       flush_o,
   output logic       stall_o,
   output logic       illegal_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MUL_WAIT = 2'd2
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_NOP  = 7'b0000000;

   // {ALUOp[1:0], ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch}
   localparam logic [7:0] CW_R    = 8'b10_0_1_0_0_0_0;
   localparam logic [7:0] CW_ADDI = 8'b00_1_1_0_0_0_0;
   localparam logic [7:0] CW_LD   = 8'b00_1_1_1_1_0_0;
   localparam logic [7:0] CW_SD   = 8'b00_1_0_0_0_1_0;
   localparam logic [7:0] CW_BEQ  = 8'b01_0_0_0_0_0_1;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

`ifdef HAZARD_CONTROL_MULDIV_EN
   localparam logic [6:0] F7_MUL   = 7'b0000001;
   localparam logic [7:0] CW_MUL   = 8'b11_0_1_0_0_0_0;
   localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);
`else
   logic unused_funct7;
   assign unused_funct7 = ^funct7_i;
`endif

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] ctrl_q, ctrl_d;
   logic       illegal_q, illegal_d;
   logic       flush_c, stall_c;

   logic [7:0] dec_word;
   logic       dec_illegal;
   logic       dec_beq;
   logic       dec_mul;

   always_comb begin
      dec_word    = 8'h00;
      dec_illegal = 1'b0;
      dec_beq     = 1'b0;
      dec_mul     = 1'b0;
      case (Op_i)
         OP_R: begin
            dec_word = CW_R;
`ifdef HAZARD_CONTROL_MULDIV_EN
            if (funct7_i == F7_MUL) begin
               dec_word = CW_MUL;
               dec_mul  = 1'b1;
            end
`endif
         end
         OP_ADDI: dec_word = CW_ADDI;
         OP_LD:   dec_word = CW_LD;
         OP_SD:   dec_word = CW_SD;
         OP_BEQ: begin
            dec_word = CW_BEQ;
            dec_beq  = 1'b1;
         end
         OP_NOP:  dec_word = 8'h00;
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      illegal_d = 1'b0;
      flush_c   = 1'b0;
      stall_c   = 1'b0;
      case (state_q)
         RUN: begin
            cnt_d = 4'd0;
            if (load_use_i) begin
               // bubble: branch and multiply detection wait for the retry
               stall_c = 1'b1;
               ctrl_d  = 8'h00;
            end else if (!valid_i) begin
               ctrl_d = 8'h00;
            end else begin
               ctrl_d    = dec_word;
               illegal_d = dec_illegal;
               if (dec_beq && is_equal_i) begin
                  flush_c = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     state_d = FLUSH;
                     cnt_d   = FLUSH_INIT;
                  end
               end else if (dec_mul) begin
`ifdef HAZARD_CONTROL_MULDIV_EN
                  state_d = MUL_WAIT;
                  cnt_d   = MUL_INIT;
`endif
               end
            end
         end
         FLUSH: begin
            flush_c = 1'b1;
            ctrl_d  = 8'h00;
            if (cnt_q <= 4'd1) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         MUL_WAIT: begin
            stall_c = 1'b1;
            if (cnt_q <= 4'd1) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
            ctrl_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         cnt_q     <= 4'd0;
         ctrl_q    <= 8'h00;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   // load_use_i is combinational into stall, so reset must mask it directly
   assign flush_o   = flush_c & ~rst_i;
   assign stall_o   = stall_c & ~rst_i;
   assign Control_o = ctrl_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: fixed vector table, hand-written reset/flush/multiply sequences, random run against a cycle model.
module tb_hazard_control;

   localparam int MUL_LAT   = 4;
   localparam int FLUSH_CYC = 3;

`ifdef HAZARD_CONTROL_MULDIV_EN
   localparam bit         MUL_EN   = 1'b1;
   localparam logic [7:0] MUL_CTRL = 8'b11010000;
`else
   localparam bit         MUL_EN   = 1'b0;
   localparam logic [7:0] MUL_CTRL = 8'b10010000;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       valid_i;
   logic [6:0] Op_i;
   logic [6:0] funct7_i;
   logic       is_equal_i;
   logic       load_use_i;
   logic [7:0] Control_o;
   logic       flush_o;
   logic       stall_o;
   logic       illegal_o;

   hazard_control #(.MUL_LAT(MUL_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .Op_i       (Op_i),
      .funct7_i   (funct7_i),
      .is_equal_i (is_equal_i),
      .load_use_i (load_use_i),
      .Control_o  (Control_o),
      .flush_o    (flush_o),
      .stall_o    (stall_o),
      .illegal_o  (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   // reference: remaining forced-flush / forced-stall cycles plus expected registered outputs
   int         m_flush_rem;
   int         m_mul_rem;
   logic [7:0] m_ctrl;
   logic       m_ill;
   logic       last_fl, last_st;

   typedef struct {
      logic       v;
      logic [6:0] op;
      logic [6:0] f7;
      logic       eq;
      logic       lu;
      logic [7:0] ctrl;
      logic       fl;
      logic       st;
      logic       ill;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic ref_decode(input logic [6:0] op, input logic [6:0] f7,
                             output logic [7:0] w, output logic ill, output logic br, output logic mul);
      ill = 1'b0; br = 1'b0; mul = 1'b0;
      case (op)
         7'b0110011: begin
            if (MUL_EN && f7 == 7'b0000001) begin w = 8'b11010000; mul = 1'b1; end
            else w = 8'b10010000;
         end
         7'b0010011: w = 8'b00110000;
         7'b0000011: w = 8'b00111100;
         7'b0100011: w = 8'b00100010;
         7'b1100011: begin w = 8'b01000001; br = 1'b1; end
         7'b0000000: w = 8'h00;
         default: begin w = 8'h00; ill = 1'b1; end
      endcase
   endtask

   task automatic model_reset();
      m_flush_rem = 0;
      m_mul_rem   = 0;
      m_ctrl      = 8'h00;
      m_ill       = 1'b0;
   endtask

   // One cycle: compare registered outputs, apply inputs, compare combinational outputs, clock.
   task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                        input logic eq, input logic lu);
      logic [7:0] w;
      logic       ill, br, mul, e_fl, e_st;
      logic [7:0] n_ctrl;
      logic       n_ill;
      chk("ctrl_reg", Control_o, m_ctrl);
      chk("illegal_reg", illegal_o, m_ill);
      valid_i = v; Op_i = op; funct7_i = f7; is_equal_i = eq; load_use_i = lu;
      #2;
      ref_decode(op, f7, w, ill, br, mul);
      e_fl = 1'b0; e_st = 1'b0; n_ill = 1'b0; n_ctrl = 8'h00;
      if (m_flush_rem > 0) begin
         e_fl = 1'b1;
         m_flush_rem--;
      end else if (m_mul_rem > 0) begin
         e_st   = 1'b1;
         n_ctrl = m_ctrl;
         m_mul_rem--;
      end else if (lu) begin
         e_st = 1'b1;
      end else if (v) begin
         n_ctrl = w;
         n_ill  = ill;
         if (br && eq) begin
            e_fl        = 1'b1;
            m_flush_rem = FLUSH_CYC - 1;
         end else if (mul) begin
            m_mul_rem = MUL_LAT - 1;
         end
      end
      last_fl = flush_o;
      last_st = stall_o;
      chk("flush", flush_o, e_fl);
      chk("stall", stall_o, e_st);
      chk("flush_stall_excl", flush_o & stall_o, 1'b0);
      m_ctrl = n_ctrl;
      m_ill  = n_ill;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 7'h00, 7'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #2;
      chk("rst_ctrl", Control_o, 8'h00);
      chk("rst_flush", flush_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_illegal", illegal_o, 1'b0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
   endtask

   initial begin
      int nf;
      logic [6:0] ops[7];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000, 7'b1111111};

      tbl[0]  = '{1'b1, 7'b0000011, 7'h00, 1'b0, 1'b0, 8'b00111100, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 7'b0100011, 7'h00, 1'b0, 1'b0, 8'b00100010, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 7'b0010011, 7'h00, 1'b0, 1'b0, 8'b00110000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 7'b0110011, 7'h00, 1'b0, 1'b0, 8'b10010000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 7'b1100011, 7'h00, 1'b0, 1'b0, 8'b01000001, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 7'b1100011, 7'h00, 1'b1, 1'b0, 8'b01000001, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 7'b1100011, 7'h00, 1'b1, 1'b1, 8'b00000000, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 7'b0000000, 7'h00, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 7'b1111111, 7'h00, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 7'b0000011, 7'h00, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 7'b0000011, 7'h00, 1'b0, 1'b1, 8'b00000000, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 7'b0110011, 7'h01, 1'b0, 1'b0, MUL_CTRL,    1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 7'b1010101, 7'h00, 1'b0, 1'b1, 8'b00000000, 1'b0, 1'b1, 1'b0};

      valid_i = 1'b0; Op_i = 7'h00; funct7_i = 7'h00; is_equal_i = 1'b0;
      load_use_i = 1'b1;
      rst_i = 1'b1;
      model_reset();
      last_fl = 1'b0; last_st = 1'b0;
      #3;
      chk("por_ctrl", Control_o, 8'h00);
      chk("por_stall_masked", stall_o, 1'b0);
      chk("por_flush", flush_o, 1'b0);
      load_use_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      idle(2);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].f7, tbl[i].eq, tbl[i].lu);
         chk($sformatf("vec%0d_flush", i), last_fl, tbl[i].fl);
         chk($sformatf("vec%0d_stall", i), last_st, tbl[i].st);
         chk($sformatf("vec%0d_ctrl", i), Control_o, tbl[i].ctrl);
         chk($sformatf("vec%0d_illegal", i), illegal_o, tbl[i].ill);
         idle(5);
      end

      // decode sweep with one-cycle illegal pulse
      drive(1'b1, 7'b0000011, 7'h00, 1'b0, 1'b0);
      chk("sweep_ld", Control_o, 8'b00111100);
      drive(1'b1, 7'b0100011, 7'h00, 1'b0, 1'b0);
      chk("sweep_sd", Control_o, 8'b00100010);
      drive(1'b1, 7'b1111111, 7'h00, 1'b0, 1'b0);
      chk("sweep_ill_ctrl", Control_o, 8'h00);
      chk("sweep_ill_on", illegal_o, 1'b1);
      idle(1);
      chk("sweep_ill_off", illegal_o, 1'b0);
      idle(2);

      // flush length for a taken and a not-taken beq
      drive(1'b1, 7'b1100011, 7'h00, 1'b1, 1'b0);
      nf = int'(last_fl);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 7'b1100011, 7'h00, 1'b1, 1'b0);
         if (k < FLUSH_CYC - 1) nf += int'(last_fl);
      end
      chk("flush_len_taken", 8'(nf), 8'(FLUSH_CYC));
      idle(4);
      drive(1'b1, 7'b1100011, 7'h00, 1'b0, 1'b0);
      nf = int'(last_fl);
      idle(1);
      nf += int'(last_fl);
      chk("flush_len_not_taken", 8'(nf), 8'd0);
      idle(2);

      // load-use beats a taken branch, branch retried next cycle
      drive(1'b1, 7'b1100011, 7'h00, 1'b1, 1'b1);
      chk("prio_stall", last_st, 1'b1);
      chk("prio_flush", last_fl, 1'b0);
      chk("prio_ctrl", Control_o, 8'h00);
      drive(1'b1, 7'b1100011, 7'h00, 1'b1, 1'b0);
      chk("prio_retry_flush", last_fl, 1'b1);
      idle(4);

      // async reset in the middle of a flush
      drive(1'b1, 7'b1100011, 7'h00, 1'b1, 1'b0);
      #2;
      chk("mid_flush_active", flush_o, 1'b1);
      rst_i = 1'b1;
      #1;
      chk("mid_flush_abort", flush_o, 1'b0);
      chk("mid_flush_ctrl", Control_o, 8'h00);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
      idle(3);

      // multiply, then reset in the second stall cycle
      drive(1'b1, 7'b0110011, 7'h01, 1'b0, 1'b0);
      chk("mul_ctrl", Control_o, MUL_CTRL);
      idle(1);
      chk("mul_stall1", last_st, MUL_EN);
      valid_i = 1'b0; Op_i = 7'h00; funct7_i = 7'h00;
      #2;
      chk("mul_stall2", stall_o, MUL_EN);
      rst_i = 1'b1;
      #1;
      chk("mul_rst_stall", stall_o, 1'b0);
      chk("mul_rst_ctrl", Control_o, 8'h00);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
      idle(3);

      // full multiply length without interruption
      drive(1'b1, 7'b0110011, 7'h01, 1'b0, 1'b0);
      nf = 0;
      for (int k = 0; k < MUL_LAT + 1; k++) begin
         drive(1'b1, 7'b0000011, 7'h00, 1'b0, 1'b0);
         nf += int'(last_st);
      end
      chk("mul_stall_len", 8'(nf), MUL_EN ? 8'(MUL_LAT - 1) : 8'd0);
      idle(3);

      for (int c = 0; c < 2000; c++) begin
         logic [6:0] op, f7;
         if ($urandom_range(0, 249) == 0) do_reset();
         op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
         f7 = ($urandom_range(0, 2) == 0) ? 7'h01 : 7'($urandom_range(0, 1) * 32);
         drive($urandom_range(0, 9) != 0, op, f7, 1'($urandom), $urandom_range(0, 4) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
